// File: rtl/display_scan_ctrl_if.sv
// Display-side bundle: shadow load strobe, per-digit controls and the registered scan outputs.
// The master modport drives the controls; the slave is the scan controller.
interface display_scan_ctrl_if;
    logic [15:0] bcd_in;
    logic        load;
    logic [3:0]  blink_mask;
    logic        lz_blank;
    logic        disp_on;
    logic [3:0]  dig_bcd;
    logic        dig_en;
    logic        dig_set;
    logic [3:0]  an;
    logic        bcd_err;

    modport master (
        output bcd_in, load, blink_mask, lz_blank, disp_on,
        input  dig_bcd, dig_en, dig_set, an, bcd_err
    );

    modport slave (
        input  bcd_in, load, blink_mask, lz_blank, disp_on,
        output dig_bcd, dig_en, dig_set, an, bcd_err
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed BCD scan driver; every output is registered, one clk behind internal state.
// No backpressure: the scan free-runs and a load strobe is always accepted into the shadow register.
module display_scan_ctrl #(
    parameter int SCAN_DIV    = 1000,
    parameter int BLINK_SCANS = 125
) (
    input  logic                 clk,
    input  logic                 rst,
    display_scan_ctrl_if.slave   bus
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int SW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] S_LAST = SW'(BLINK_SCANS - 1);

    logic [PW-1:0] p_q, p_d;
    logic [1:0]    idx_q, idx_d;
    logic [SW-1:0] s_q, s_d;
    logic          blink_q, blink_d;
    logic [15:0]   shadow_q, shadow_d;

    logic [3:0]    an_q, an_d;
    logic [3:0]    dig_bcd_q, dig_bcd_d;
    logic          dig_en_q, dig_en_d;
    logic          dig_set_q, dig_set_d;
    logic          bcd_err_q, bcd_err_d;

    logic          slot_end;
    logic          lead_zero;

    always_comb begin
        slot_end = (p_q == P_LAST);
        p_d      = slot_end ? '0 : p_q + 1'b1;
        idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
        s_d      = s_q;
        blink_d  = blink_q;
        if (slot_end && idx_q == 2'd3) begin
            if (s_q == S_LAST) begin
                s_d     = '0;
                blink_d = ~blink_q;
            end else begin
                s_d = s_q + 1'b1;
            end
        end
        shadow_d = bus.load ? bus.bcd_in : shadow_q;

        // Digit 0 always shows, so a value of zero still displays "0".
        case (idx_q)
            2'd3:    lead_zero = (shadow_q[15:12] == 4'd0);
            2'd2:    lead_zero = (shadow_q[15:8]  == 8'd0);
            2'd1:    lead_zero = (shadow_q[15:4]  == 12'd0);
            default: lead_zero = 1'b0;
        endcase

        dig_bcd_d = shadow_q[{idx_q, 2'b00} +: 4];
        an_d      = (bus.disp_on && p_q != '0) ? ~(4'b0001 << idx_q) : 4'b1111;
        dig_en_d  = bus.disp_on && !(bus.lz_blank && lead_zero);
        dig_set_d = bus.disp_on && !(bus.blink_mask[idx_q] && blink_q);

        bcd_err_d = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (shadow_q[4*k +: 4] > 4'd9) bcd_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q       <= '0;
            idx_q     <= 2'd0;
            s_q       <= '0;
            blink_q   <= 1'b0;
            shadow_q  <= 16'h0000;
            an_q      <= 4'b1111;
            dig_bcd_q <= 4'd0;
            dig_en_q  <= 1'b0;
            dig_set_q <= 1'b0;
            bcd_err_q <= 1'b0;
        end else begin
            p_q       <= p_d;
            idx_q     <= idx_d;
            s_q       <= s_d;
            blink_q   <= blink_d;
            shadow_q  <= shadow_d;
            an_q      <= an_d;
            dig_bcd_q <= dig_bcd_d;
            dig_en_q  <= dig_en_d;
            dig_set_q <= dig_set_d;
            bcd_err_q <= bcd_err_d;
        end
    end

    assign bus.an      = an_q;
    assign bus.dig_bcd = dig_bcd_q;
    assign bus.dig_en  = dig_en_q;
    assign bus.dig_set = dig_set_q;
    assign bus.bcd_err = bcd_err_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl at SCAN_DIV=4, BLINK_SCANS=2: a per-cycle vector table
// for scan / blanking / blink, then hand sequences for bad BCD, display-off and async reset.
module tb_display_scan_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    display_scan_ctrl_if bus ();

    display_scan_ctrl #(.SCAN_DIV(4), .BLINK_SCANS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        ld;
        logic [15:0] bcd;
        logic [3:0]  mask;
        logic        lz;
        logic        disp;
        logic [3:0]  e_an;
        logic [3:0]  e_bcd;
        logic        e_en;
        logic        e_set;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input logic [3:0] an, input logic [3:0] bcd,
                             input logic en, input logic set, input logic err);
        check({nm, " an"},      16'(bus.an),      16'(an));
        check({nm, " dig_bcd"}, 16'(bus.dig_bcd), 16'(bcd));
        check({nm, " dig_en"},  16'(bus.dig_en),  16'(en));
        check({nm, " dig_set"}, 16'(bus.dig_set), 16'(set));
        check({nm, " bcd_err"}, 16'(bus.bcd_err), 16'(err));
    endtask

    task automatic add_row(input logic [3:0] mask, input logic lz, input logic [3:0] an,
                           input logic [3:0] bcd, input logic en, input logic set);
        vec_t v;
        v.ld = 1'b0; v.bcd = 16'h0000; v.mask = mask; v.lz = lz; v.disp = 1'b1;
        v.e_an = an; v.e_bcd = bcd; v.e_en = en; v.e_set = set; v.e_err = 1'b0;
        vecs.push_back(v);
    endtask

    // One slot: dead cycle with all anodes off, then three cycles on the selected anode.
    task automatic add_slot(input logic [3:0] mask, input logic lz, input logic [3:0] an_on,
                            input logic [3:0] bcd, input logic en, input logic set);
        add_row(mask, lz, 4'b1111, bcd, en, set);
        for (int k = 0; k < 3; k++) add_row(mask, lz, an_on, bcd, en, set);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.bcd_in = 16'h0000; bus.load = 1'b0; bus.blink_mask = 4'b0000;
        bus.lz_blank = 1'b0;   bus.disp_on = 1'b0;

        // Scans 1-2: shadow 1234, no blanking, no blink.
        for (int sc = 0; sc < 2; sc++) begin
            add_slot(4'b0000, 1'b0, 4'b1110, 4'h4, 1'b1, 1'b1);
            add_slot(4'b0000, 1'b0, 4'b1101, 4'h3, 1'b1, 1'b1);
            add_slot(4'b0000, 1'b0, 4'b1011, 4'h2, 1'b1, 1'b1);
            add_slot(4'b0000, 1'b0, 4'b0111, 4'h1, 1'b1, 1'b1);
        end
        // Scan 3: shadow 0050, lz on, digit 0 blinking in its off phase.
        add_slot(4'b0001, 1'b1, 4'b1110, 4'h0, 1'b1, 1'b0);
        add_slot(4'b0001, 1'b1, 4'b1101, 4'h5, 1'b1, 1'b1);
        add_slot(4'b0001, 1'b1, 4'b1011, 4'h0, 1'b0, 1'b1);
        add_slot(4'b0001, 1'b1, 4'b0111, 4'h0, 1'b0, 1'b1);
        // Scans 4-7: lz off; blink off-phase in scans 4 and 7 only.
        for (int sc = 4; sc <= 7; sc++) begin
            add_slot(4'b0001, 1'b0, 4'b1110, 4'h0, 1'b1, (sc == 5 || sc == 6));
            add_slot(4'b0001, 1'b0, 4'b1101, 4'h5, 1'b1, 1'b1);
            add_slot(4'b0001, 1'b0, 4'b1011, 4'h0, 1'b1, 1'b1);
            add_slot(4'b0001, 1'b0, 4'b0111, 4'h0, 1'b1, 1'b1);
        end
        // Load 1234 on the very first cycle (shadow still 0 on that output); load 0050 on a slot end.
        vecs[0].ld = 1'b1;  vecs[0].bcd = 16'h1234;  vecs[0].e_bcd = 4'h0;
        vecs[31].ld = 1'b1; vecs[31].bcd = 16'h0050;

        #2;
        check_all("reset async", 4'b1111, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_all("reset held", 4'b1111, 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.load = vecs[i].ld; bus.bcd_in = vecs[i].bcd; bus.blink_mask = vecs[i].mask;
            bus.lz_blank = vecs[i].lz; bus.disp_on = vecs[i].disp;
            tick();
            check_all($sformatf("row%0d", i), vecs[i].e_an, vecs[i].e_bcd,
                      vecs[i].e_en, vecs[i].e_set, vecs[i].e_err);
        end

        // Bad BCD loaded exactly on a slot end (p=3, idx=0), rows 112-119.
        bus.load = 1'b0; bus.blink_mask = 4'b0000; bus.lz_blank = 1'b0; bus.disp_on = 1'b1;
        tick(); tick(); tick();
        bus.load = 1'b1; bus.bcd_in = 16'h00A0;
        tick();
        bus.load = 1'b0;
        check("collide old err", 16'(bus.bcd_err), 16'h0);
        tick();
        check_all("collide new slot", 4'b1111, 4'hA, 1'b1, 1'b1, 1'b1);
        tick();
        bus.load = 1'b1; bus.bcd_in = 16'h0000;
        tick();
        bus.load = 1'b0;
        check("err before clear", 16'(bus.bcd_err), 16'h1);
        tick();
        check_all("err cleared", 4'b1101, 4'h0, 1'b1, 1'b1, 1'b0);

        // Display off for 10 cycles, rows 120-129; scan keeps running underneath.
        bus.disp_on = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_all($sformatf("off%0d", i), 4'b1111, (i < 4) ? 4'h0 : 4'h0, 1'b0, 1'b0, 1'b0);
        end
        bus.disp_on = 1'b1;
        tick();
        check("resume row130 an", 16'(bus.an), 16'h000E);
        tick();
        tick();
        check("resume row132 an", 16'(bus.an), 16'h000F);
        bus.load = 1'b1; bus.bcd_in = 16'h8888;
        tick();
        bus.load = 1'b0;
        check("resume row133 an", 16'(bus.an), 16'h000D);
        tick(); tick(); tick(); tick();
        check("pre-reset an", 16'(bus.an), 16'h000B);
        check("pre-reset bcd", 16'(bus.dig_bcd), 16'h0008);

        // Async reset mid-slot (idx 2, p 1): outputs clear well before the next edge.
        #3;
        rst = 1'b1;
        #1;
        check_all("mid-slot rst", 4'b1111, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check_all("post-rst p0", 4'b1111, 4'h0, 1'b1, 1'b1, 1'b0);
        tick();
        check_all("post-rst p1", 4'b1110, 4'h0, 1'b1, 1'b1, 1'b0);
        tick(); tick(); tick();
        check("post-rst idx1 dead", 16'(bus.an), 16'h000F);
        tick();
        check("post-rst idx1 on", 16'(bus.an), 16'h000D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clock cycles per digit slot (legal range >= 2).
REQ-002 SHALL have parameter BLINK_SCANS, default 125, full 4-digit scans per blink half-period (legal range >= 1).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port bcd_in  input  16  four BCD digits; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
REQ-006 SHALL have port load  input  1  one-cycle strobe that captures bcd_in into the shadow register.
REQ-007 SHALL have port blink_mask  input  4  bit k=1 makes digit k blink.
REQ-008 SHALL have port lz_blank  input  1  enables leading-zero blanking.
REQ-009 SHALL have port disp_on  input  1  global display enable.
REQ-010 SHALL have port dig_bcd  output  4  BCD value for the shared seven-segment decoder.
REQ-011 SHALL have port dig_en  output  1  decoder En; 0 blanks the digit.
REQ-012 SHALL have port dig_set  output  1  decoder enSet; 0 blanks the digit during the blink-off phase.
REQ-013 SHALL have port an  output  4  active-low digit select; an[k]=0 drives digit k.
REQ-014 SHALL have port bcd_err  output  1  high while any shadow nibble is > 9.

Function
REQ-015 SHALL keep prescaler p, counting 0..SCAN_DIV-1 and wrapping to 0; slot end is the cycle where p = SCAN_DIV-1.
REQ-016 SHALL advance 2-bit digit index idx at each slot end, wrapping 3 -> 0.
REQ-017 SHALL keep scan counter s, incremented at each slot end with idx = 3; when s reaches BLINK_SCANS-1 at that event, s SHALL clear and blink_phase SHALL toggle.
REQ-018 SHALL capture bcd_in into shadow on any cycle with load = 1; the display SHALL never read bcd_in directly.
REQ-019 SHALL register all outputs, each reflecting internal state (idx, p, shadow, blink_phase) with exactly one clock of latency.
REQ-020 SHALL set dig_bcd = shadow nibble idx for the whole slot.
REQ-021 SHALL drive an = 4'b1111 for the dead cycle p = 0 of every slot (anti-ghosting), and an = ~(4'b0001 << idx) for p >= 1.
REQ-022 SHALL force an = 4'b1111, dig_en = 0 and dig_set = 0 while disp_on = 0, with counters continuing to run.
REQ-023 SHALL set dig_set = 0 when blink_mask[idx] = 1 and blink_phase = 1, and dig_set = 1 otherwise (disp_on = 1).
REQ-024 SHALL set dig_en = 0 when lz_blank = 1, idx != 0, and shadow nibbles idx..3 are all zero; otherwise dig_en = 1 (disp_on = 1). Digit 0 is never leading-zero blanked.
REQ-025 SHALL pass nibbles > 9 unchanged to dig_bcd and set bcd_err = 1, with the same one-clock latency, until a load clears them.
REQ-026 SHALL apply a load coinciding with a slot end as follows: the new shadow is visible on outputs from the first cycle of the new slot.
REQ-027 SHALL apply blink_mask, lz_blank and disp_on changes at any cycle, visible on outputs one clock later, without resetting any counter.

Reset
REQ-028 SHALL, on rst = 1 and independent of clk, clear p, idx, s, blink_phase and shadow to 0, and drive an = 4'b1111, dig_bcd = 0, dig_en = 0, dig_set = 0 and bcd_err = 0.
REQ-029 SHALL start the first slot (idx = 0, p = 0) on the first clock edge after rst deasserts; rst asserted mid-slot SHALL abort the scan immediately.

Verification (SCAN_DIV=4, BLINK_SCANS=2)
REQ-030 SHALL check scan sequence: load 16'h1234, disp_on=1, mask=0 -> per 4-cycle slot: an 1111 then 1110 x3 with dig_bcd=4; then the same pattern for 1101/3, 1011/2, 0111/1; repeats.
REQ-031 SHALL check leading-zero blanking: load 16'h0050, lz_blank=1 -> dig_en=0 in slots 3 and 2; dig_en=1 in slots 1 (bcd 5) and 0 (bcd 0); with lz_blank=0, all four slots have dig_en=1.
REQ-032 SHALL check blinking: mask=4'b0001 -> dig_set=0 only in slot 0 during scans 3-4, 7-8, ...; other slots dig_set=1 throughout.
REQ-033 SHALL check load/slot-end collision and bad BCD: load 16'h00A0 on a slot end -> next slot shows the new data; bcd_err=1 one clock after load; a later load of 16'h0000 clears bcd_err.
REQ-034 SHALL check asynchronous reset: rst pulsed mid-slot with idx=2 -> outputs reach reset values before the next clk edge; after release, first slot is idx 0 with shadow 0.
REQ-035 SHALL check display off: disp_on=0 for 10 cycles -> an=1111, dig_en=0 and dig_set=0 throughout; on return to 1, the scan position continues uninterrupted.
